inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the 16-bit TSC datapath. It owns the fetch PC and runs the read handshake with instruction memory. It latches each returned word into an instruction register and presents it, with its PC, to the decode/control stage. A one-deep valid/ack handshake decouples it from downstream, and a redirect input from branch/jump resolution flushes it and restarts fetch at a new target.

## Interface
- `RESET_PC`, 16'h0000, first address fetched after reset
- `WORD_SIZE`, 16, instruction/address width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high reset
- `i_readM` out 1: instruction-memory read request
- `i_address` out WORD_SIZE: read address, stable while `i_readM`=1
- `i_data` in WORD_SIZE: returned instruction word, valid when `i_inputReady`=1
- `i_inputReady` in 1: one-cycle pulse, memory has completed the current read
- `inst` out WORD_SIZE: instruction register, drives the control unit's `inst`
- `inst_valid` out 1: `inst`/`pc` hold an unconsumed instruction
- `inst_ack` in 1: downstream consumes `inst` this cycle; ignored when `inst_valid`=0
- `pc` out WORD_SIZE: address of `inst`
- `pc_plus1` out WORD_SIZE: `pc`+1 mod 2^16, for JAL/JRL link and branch base
- `redirect` in 1: flush and restart fetch at `redirect_target`
- `redirect_target` in WORD_SIZE: new fetch address
- `fetch_count` out 16: number of instructions acknowledged since reset, wraps

## Operation
- Internal registers: `state`, `fetch_pc`, `inst`, `pc`, `fetch_count`.
- States:
  - IDLE: post-reset only.
  - REQ: request outstanding.
  - FULL: IR valid, waiting for ack.
  - FLUSH: stale request outstanding after a redirect; its data will be discarded.
- Outputs are decoded from registered state:
  - `i_readM`=1 in REQ and FLUSH, 0 otherwise.
  - `i_address`=`fetch_pc` in REQ; the held stale address in FLUSH.
  - `inst_valid`=1 only in FULL.
- Transitions, evaluated at each rising edge, with `redirect` having highest priority in every state:
  - IDLE -> REQ unconditionally.
  - REQ, `i_inputReady`=1, no redirect: `inst`<=`i_data`, `pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+1, go FULL.
  - REQ, `i_inputReady`=0, no redirect: stay; address held.
  - FULL, `inst_ack`=1, no redirect: `fetch_count`+=1, go REQ.
  - FULL, no ack: hold everything.
  - REQ with redirect and `i_inputReady`=0: request cannot be withdrawn. Latch `fetch_pc`<=`redirect_target`, keep old address on `i_address`, go FLUSH.
  - REQ with redirect and `i_inputReady`=1: data discarded, `fetch_pc`<=target, go REQ.
  - FULL with redirect: IR invalidated, not counted even if `inst_ack`=1; `fetch_pc`<=target, go REQ.
  - FLUSH, `i_inputReady`=1: data discarded, go REQ. A redirect in the same cycle updates `fetch_pc`.
  - FLUSH, `i_inputReady`=0: stay. A redirect updates `fetch_pc` only; the last redirect wins.
  - IDLE with redirect: `fetch_pc`<=target, go REQ.
- Arithmetic: all PC and count adds are 16-bit modulo; 16'hFFFF+1 = 16'h0000.
- `inst`, `pc`, `pc_plus1` hold their values outside FULL but are meaningful only when `inst_valid`=1.

## Timing
- Reset (async, immediate): `state`=IDLE, `fetch_pc`=RESET_PC, `inst`=0, `pc`=0, `fetch_count`=0.
  - Resulting outputs: `i_readM`=0, `i_address`=RESET_PC, `inst_valid`=0, `pc_plus1`=1.
- Reset asserted mid-request abandons the request; memory must tolerate `i_readM` dropping.
- First `i_readM`=1 is in the first cycle after reset deasserts.
- Latency: the `i_inputReady` edge -> `inst_valid`=1 in the next cycle.
- Throughput: ack edge -> `i_readM`=1 in the next cycle. One bubble per instruction plus memory latency; at most one request outstanding.
- Redirect to new-address request:
  - REQ/FULL/IDLE: next cycle.
  - FLUSH: the cycle after the stale `i_inputReady`.
- `i_address` never changes while `i_readM`=1 except on the cycle a request completes.

## Test plan
- Reset release, RESET_PC=0, memory returns 16'h6A05 after 2 cycles -> `i_address`=0, `inst`=16'h6A05, `pc`=0, `pc_plus1`=1, `inst_valid`=1 one cycle after `i_inputReady`.
- Stream 3 words with `inst_ack` delayed 0, 3, 1 cycles -> `inst`/`pc` stable while unacked, addresses 0,1,2 issued in order, `fetch_count`=3.
- `redirect`=1, target 16'h0040, during REQ with no `i_inputReady` -> FLUSH. Stale address held until the pulse, stale data not presented, next request at 16'h0040.
- `redirect` and `inst_ack` same cycle in FULL -> `fetch_count` unchanged, `inst_valid`=0 next cycle, `i_address`=target.
- `redirect` to 16'hFFFF, then fetch and ack -> `pc`=16'hFFFF, `pc_plus1`=0, next `i_address`=16'h0000.
- Assert `reset` mid-FULL for half a cycle -> outputs immediately at reset values, `fetch_count`=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory read handshake plus the decode-side IR handshake.
interface inst_fetch_if #(
    parameter int unsigned WORD_SIZE = 16
);
    localparam int unsigned CNT_W = 16;

    // Instruction-memory side
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [WORD_SIZE-1:0] i_data;
    logic                 i_inputReady;

    // Decode / control side
    logic [WORD_SIZE-1:0] inst;
    logic                 inst_valid;
    logic                 inst_ack;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pc_plus1;

    // Branch / jump resolution side
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_target;

    // Statistics
    logic [CNT_W-1:0]     fetch_count;

    // Fetch stage drives requests and the IR
    modport master (
        output i_readM, i_address, inst, inst_valid, pc, pc_plus1, fetch_count,
        input  i_data, i_inputReady, inst_ack, redirect, redirect_target
    );

    // Memory / decode / branch logic surrounding the fetch stage
    modport slave (
        input  i_readM, i_address, inst, inst_valid, pc, pc_plus1, fetch_count,
        output i_data, i_inputReady, inst_ack, redirect, redirect_target
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, runs the memory read handshake,
// holds one instruction in the IR for decode and restarts on redirect.
module inst_fetch #(
    parameter int unsigned          WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          reset,
    inst_fetch_if.master  bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FULL  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t               state_q,    state_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0] inst_q,     inst_d;
    logic [WORD_SIZE-1:0] pc_q,       pc_d;
    logic [WORD_SIZE-1:0] pc_plus1_q, pc_plus1_d;
    logic [CNT_W-1:0]     count_q,    count_d;
    logic                 readm_q,    readm_d;
    logic [WORD_SIZE-1:0] addr_q,     addr_d;
    logic                 valid_q,    valid_d;

    // Next-state, datapath updates and output decode of the next state
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_target;
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    // An in-flight read cannot be withdrawn; wait it out in FLUSH
                    fetch_pc_d = bus.redirect_target;
                    state_d    = bus.i_inputReady ? S_REQ : S_FLUSH;
                end else if (bus.i_inputReady) begin
                    inst_d     = bus.i_data;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + WORD_SIZE'(1);
                    state_d    = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.redirect) begin
                    // Wrong-path instruction: dropped and never counted
                    fetch_pc_d = bus.redirect_target;
                    state_d    = S_REQ;
                end else if (bus.inst_ack) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = S_REQ;
                end
            end
            S_FLUSH: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_target;
                end
                if (bus.i_inputReady) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs track the state being entered
        pc_plus1_d = pc_d + WORD_SIZE'(1);
        readm_d    = (state_d == S_REQ) || (state_d == S_FLUSH);
        valid_d    = (state_d == S_FULL);
        // The stale address stays on the bus until its read completes
        addr_d     = (state_d == S_FLUSH) ? addr_q : fetch_pc_d;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            inst_q     <= '0;
            pc_q       <= '0;
            pc_plus1_q <= WORD_SIZE'(1);
            count_q    <= '0;
            readm_q    <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            pc_plus1_q <= pc_plus1_d;
            count_q    <= count_d;
            readm_q    <= readm_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
        end
    end

    // Drive the bus from the registers
    assign bus.i_readM     = readm_q;
    assign bus.i_address   = addr_q;
    assign bus.inst        = inst_q;
    assign bus.inst_valid  = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = pc_plus1_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage.
module tb_inst_fetch;
    logic clk;
    logic reset;

    inst_fetch_if #(.WORD_SIZE(16)) bus ();

    inst_fetch #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err;
    int n_checks;

    // Model: one optional outstanding read (possibly marked for discard),
    // one optional IR entry, the next address to fetch and the ack count.
    logic        m_started;
    logic        m_outstanding;
    logic        m_discard;
    logic [15:0] m_req_addr;
    logic [15:0] m_next;
    logic        m_ir_valid;
    logic [15:0] m_inst;
    logic [15:0] m_pc;
    logic [15:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started     = 1'b0;
        m_outstanding = 1'b0;
        m_discard     = 1'b0;
        m_req_addr    = 16'h0000;
        m_next        = 16'h0000;
        m_ir_valid    = 1'b0;
        m_inst        = 16'h0000;
        m_pc          = 16'h0000;
        m_count       = 16'h0000;
    endtask

    task automatic model_issue();
        m_outstanding = 1'b1;
        m_discard     = 1'b0;
        m_req_addr    = m_next;
    endtask

    // One clock of the model given the inputs seen at that edge
    task automatic model_step(input logic ir, input logic [15:0] d, input logic ack,
                              input logic rd, input logic [15:0] tgt);
        if (!m_started) begin
            m_started = 1'b1;
            if (rd) m_next = tgt;
            model_issue();
        end else if (m_outstanding) begin
            if (ir && !m_discard && !rd) begin
                m_ir_valid    = 1'b1;
                m_inst        = d;
                m_pc          = m_req_addr;
                m_next        = m_req_addr + 16'd1;
                m_outstanding = 1'b0;
            end else if (ir) begin
                if (rd) m_next = tgt;
                model_issue();
            end else if (rd) begin
                m_next    = tgt;
                m_discard = 1'b1;
            end
        end else if (m_ir_valid) begin
            if (rd) begin
                m_ir_valid = 1'b0;
                m_next     = tgt;
                model_issue();
            end else if (ack) begin
                m_count    = m_count + 16'd1;
                m_ir_valid = 1'b0;
                model_issue();
            end
        end
    endtask

    // Drive inputs for one cycle (called at a falling edge), returns at the next falling edge
    task automatic cyc(input logic ir, input logic [15:0] d, input logic ack,
                       input logic rd, input logic [15:0] tgt);
        bus.i_inputReady    = ir;
        bus.i_data          = d;
        bus.inst_ack        = ack;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        @(posedge clk);
        model_step(ir, d, ack, rd, tgt);
        @(negedge clk);
    endtask

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("i_readM", 32'(bus.i_readM), 32'(m_outstanding));
            if (m_outstanding) chk("i_address", 32'(bus.i_address), 32'(m_req_addr));
            chk("inst_valid", 32'(bus.inst_valid), 32'(m_ir_valid));
            if (m_ir_valid) begin
                chk("inst", 32'(bus.inst), 32'(m_inst));
                chk("pc", 32'(bus.pc), 32'(m_pc));
                chk("pc_plus1", 32'(bus.pc_plus1), 32'(16'(m_pc + 16'd1)));
            end
            chk("fetch_count", 32'(bus.fetch_count), 32'(m_count));
        end
    end

    initial begin
        logic        ir;
        logic [15:0] tgt;
        n_err    = 0;
        n_checks = 0;
        reset    = 1'b1;
        bus.i_inputReady    = 1'b0;
        bus.i_data          = 16'h0000;
        bus.inst_ack        = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values
        chk("rst_readM", 32'(bus.i_readM), 32'h0);
        chk("rst_address", 32'(bus.i_address), 32'h0000);
        chk("rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_pc_plus1", 32'(bus.pc_plus1), 32'h0001);
        chk("rst_count", 32'(bus.fetch_count), 32'h0000);

        // First fetch: memory answers after two cycles
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("first_req", 32'(bus.i_readM), 32'h1);
        chk("first_addr", 32'(bus.i_address), 32'h0000);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 16'h6A05, 1'b0, 1'b0, 16'h0000);
        chk("first_valid", 32'(bus.inst_valid), 32'h1);
        chk("first_inst", 32'(bus.inst), 32'h6A05);
        chk("first_pc", 32'(bus.pc), 32'h0000);
        chk("first_pc_plus1", 32'(bus.pc_plus1), 32'h0001);

        // Stream with ack delays 0, 3, 1
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("stream_addr1", 32'(bus.i_address), 32'h0001);
        cyc(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
        repeat (3) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("hold_inst", 32'(bus.inst), 32'h1111);
        chk("hold_pc", 32'(bus.pc), 32'h0001);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("stream_addr2", 32'(bus.i_address), 32'h0002);
        cyc(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("stream_count", 32'(bus.fetch_count), 32'h0003);
        chk("stream_addr3", 32'(bus.i_address), 32'h0003);

        // Redirect while a read is outstanding: stale address held, data dropped
        cyc(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040);
        chk("flush_readM", 32'(bus.i_readM), 32'h1);
        chk("flush_addr", 32'(bus.i_address), 32'h0003);
        repeat (2) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("flush_addr_held", 32'(bus.i_address), 32'h0003);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
        chk("flush_no_valid", 32'(bus.inst_valid), 32'h0);
        chk("flush_new_addr", 32'(bus.i_address), 32'h0040);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
        chk("target_pc", 32'(bus.pc), 32'h0040);
        chk("target_inst", 32'(bus.inst), 32'h1234);

        // Redirect and ack together in FULL: not counted
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100);
        chk("redir_ack_count", 32'(bus.fetch_count), 32'h0003);
        chk("redir_ack_valid", 32'(bus.inst_valid), 32'h0);
        chk("redir_ack_addr", 32'(bus.i_address), 32'h0100);

        // Redirect coinciding with completion, then wrap at 16'hFFFF
        cyc(1'b1, 16'h5555, 1'b0, 1'b1, 16'hFFFF);
        chk("wrap_req_addr", 32'(bus.i_address), 32'hFFFF);
        chk("wrap_drop_valid", 32'(bus.inst_valid), 32'h0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
        chk("wrap_pc", 32'(bus.pc), 32'hFFFF);
        chk("wrap_pc_plus1", 32'(bus.pc_plus1), 32'h0000);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("wrap_next_addr", 32'(bus.i_address), 32'h0000);
        chk("wrap_count", 32'(bus.fetch_count), 32'h0004);

        // Half-cycle reset while holding an instruction
        cyc(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_readM", 32'(bus.i_readM), 32'h0);
        chk("mid_rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("mid_rst_addr", 32'(bus.i_address), 32'h0000);
        chk("mid_rst_count", 32'(bus.fetch_count), 32'h0000);
        chk("mid_rst_pc_plus1", 32'(bus.pc_plus1), 32'h0001);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("restart_addr", 32'(bus.i_address), 32'h0000);
        chk("restart_readM", 32'(bus.i_readM), 32'h1);

        // Randomized traffic; memory only answers an outstanding read
        for (int i = 0; i < 4000; i++) begin
            ir  = m_outstanding && ($urandom_range(0, 2) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            cyc(ir, 16'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 11) == 0), tgt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
